// File: rtl/ami_axi_write_bridge_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ami_axi_write_bridge_pkg : shared AXI and cache-line constants for the bridge
// Revision 1.0
// ---------------------------------------------------------------------------
package ami_axi_write_bridge_pkg;

  localparam int         LINE_BYTES     = 64;
  localparam int         LINE_OFFSET_W  = $clog2(LINE_BYTES);
  localparam int         AXI_ID_W       = 4;
  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage
`default_nettype wire

// File: rtl/ami_axi_write_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ami_axi_write_bridge : single-line AXI4 write issuer with B-response credits
// Revision 1.0
// ---------------------------------------------------------------------------
module ami_axi_write_bridge
  import ami_axi_write_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  req_grant,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [AXI_ID_W-1:0]   axi_awid,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wlast,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,
  output logic                  axi_arvalid,
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic [AXI_ID_W-1:0]   axi_arid,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_rready,
  output logic [7:0]            outstanding,
  output logic                  idle,
  output logic                  err_sticky,
  input  logic                  err_clear
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q,  w_pend_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [7:0]        cnt_q,     cnt_d;
  logic              err_q,     err_d;

  logic accept;
  logic b_match;
  logic b_spurious;
  logic err_set;
  logic credit_ok;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_addr[LINE_OFFSET_W-1:0];

  // A response with nothing outstanding is not a credit; it only flags an error.
  assign b_match    = axi_bvalid && (cnt_q != 8'd0);
  assign b_spurious = axi_bvalid && (cnt_q == 8'd0);
  assign err_set    = b_spurious || (axi_bvalid && (axi_bresp != AXI_RESP_OKAY));

  // A returning B frees a credit in the same cycle, so a full bridge can still grant.
  assign credit_ok = (cnt_q < MAX_CNT) || b_match;
  assign req_grant = rst_n
                     && (!aw_pend_q || axi_awready)
                     && (!w_pend_q  || axi_wready)
                     && credit_ok;
  assign accept    = req_valid && req_grant;

  always_comb begin
    aw_pend_d = accept || (aw_pend_q && !axi_awready);
    w_pend_d  = accept || (w_pend_q  && !axi_wready);
    addr_d    = addr_q;
    data_d    = data_q;
    if (accept) begin
      addr_d = {req_addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
      data_d = req_data;
    end

    case ({accept, b_match})
      2'b10:   cnt_d = cnt_q + 8'd1;
      2'b01:   cnt_d = cnt_q - 8'd1;
      default: cnt_d = cnt_q;
    endcase

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign axi_awvalid = aw_pend_q;
  assign axi_awaddr  = addr_q;
  assign axi_awid    = '0;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = AXI_SIZE_64B;
  assign axi_awburst = AXI_BURST_INCR;

  assign axi_wvalid  = w_pend_q;
  assign axi_wdata   = data_q;
  assign axi_wstrb   = '1;
  assign axi_wlast   = 1'b1;

  assign axi_bready  = 1'b1;

  assign axi_arvalid = 1'b0;
  assign axi_araddr  = '0;
  assign axi_arid    = '0;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = 3'd0;
  assign axi_arburst = 2'd0;
  assign axi_rready  = 1'b0;

  assign outstanding = cnt_q;
  assign err_sticky  = err_q;
  assign idle        = !rst_n || (!aw_pend_q && !w_pend_q && (cnt_q == 8'd0));

endmodule
`default_nettype wire

// File: tb/tb_ami_axi_write_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ami_axi_write_bridge : scenario tasks checked against a queue-based model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ami_axi_write_bridge;

  localparam int MAXO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [63:0]  req_addr;
  logic [511:0] req_data;
  logic         req_grant;
  logic         awvalid, awready;
  logic [63:0]  awaddr;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid, wready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic         arvalid;
  logic [63:0]  araddr;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rready;
  logic [7:0]   outstanding;
  logic         idle, err_sticky, err_clear;

  ami_axi_write_bridge #(.MAX_OUTSTANDING(MAXO), .ADDR_W(64), .DATA_W(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_grant(req_grant),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awid(awid),
    .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .axi_arvalid(arvalid), .axi_araddr(araddr), .axi_arid(arid), .axi_arlen(arlen),
    .axi_arsize(arsize), .axi_arburst(arburst), .axi_rready(rready),
    .outstanding(outstanding), .idle(idle), .err_sticky(err_sticky), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queues of accepted-but-unsent AW addresses and W lines.
  logic [63:0]  m_aw[$];
  logic [511:0] m_w[$];
  int           m_cnt = 0;
  bit           m_err = 1'b0;

  // Values expected (e_*) and observed (s_*) at the negedge of the last tick.
  logic         e_grant, e_awvalid, e_wvalid, e_idle, e_err;
  logic [7:0]   e_cnt;
  logic [63:0]  e_awaddr;
  logic [511:0] e_wdata;
  logic         s_grant, s_awvalid, s_wvalid, s_idle, s_err;
  logic [7:0]   s_cnt;
  logic [63:0]  s_awaddr;
  logic [511:0] s_wdata;
  logic [12:0]  e_ctl, s_ctl;
  bit           ev_accept, ev_aw_hs, ev_w_hs;

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] v;
    v[63:32] = $urandom();
    v[31:0]  = $urandom();
    return v;
  endfunction

  task automatic tick();
    bit set;
    @(negedge clk);
    e_grant   = rst_n && (m_aw.size() == 0 || awready) && (m_w.size() == 0 || wready)
                && (m_cnt < MAXO || (bvalid && m_cnt > 0));
    e_awvalid = (m_aw.size() != 0);
    e_wvalid  = (m_w.size() != 0);
    e_awaddr  = e_awvalid ? m_aw[0] : 64'd0;
    e_wdata   = e_wvalid ? m_w[0] : 512'd0;
    e_cnt     = 8'(m_cnt);
    e_err     = m_err;
    e_idle    = !rst_n || (m_aw.size() == 0 && m_w.size() == 0 && m_cnt == 0);
    s_grant   = req_grant;  s_awvalid = awvalid;  s_wvalid = wvalid;
    s_idle    = idle;       s_err     = err_sticky; s_cnt  = outstanding;
    s_awaddr  = awaddr;     s_wdata   = wdata;
    e_ctl     = {e_grant, e_awvalid, e_wvalid, e_idle, e_err, e_cnt};
    s_ctl     = {s_grant, s_awvalid, s_wvalid, s_idle, s_err, s_cnt};
    ev_accept = req_valid && e_grant;
    ev_aw_hs  = e_awvalid && awready;
    ev_w_hs   = e_wvalid && wready;
    @(posedge clk);
    if (!rst_n) begin
      m_aw.delete();
      m_w.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      if (ev_aw_hs) void'(m_aw.pop_front());
      if (ev_w_hs)  void'(m_w.pop_front());
      set = bvalid && (m_cnt == 0 || bresp != 2'b00);
      if (bvalid && m_cnt > 0) m_cnt--;
      if (set) m_err = 1'b1;
      else if (err_clear) m_err = 1'b0;
      if (ev_accept) begin
        m_aw.push_back((req_addr >> 6) << 6);
        m_w.push_back(req_data);
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00; err_clear = 1'b0;
    req_addr = rand_addr(); req_data = rand_line();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    req_valid = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (s_ctl !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}) begin
      n_errors++; $display("FAIL reset_ctl: got %b expected %b", s_ctl, 13'b0001000000000);
    end
    n_checks++;
    if ({bready, arvalid, rready} !== 3'b100) begin
      n_errors++; $display("FAIL reset_static: bready/arvalid/rready got %b expected 100", {bready, arvalid, rready});
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
    tick();
    n_checks++;
    if (s_ctl !== e_ctl) begin
      n_errors++; $display("FAIL post_reset_ctl: got %b expected %b", s_ctl, e_ctl);
    end
  endtask

  task automatic test_address_mask();
    idle_inputs();
    req_valid = 1'b1;
    req_addr  = 64'h123F;
    tick();
    n_checks++;
    if (s_grant !== 1'b1) begin
      n_errors++; $display("FAIL mask_grant: got %b expected 1", s_grant);
    end
    req_valid = 1'b0;
    tick();
    n_checks++;
    if (s_awvalid !== 1'b1 || s_awaddr !== 64'h1200) begin
      n_errors++; $display("FAIL mask_awaddr: got valid=%b addr=%h expected valid=1 addr=1200", s_awvalid, s_awaddr);
    end
    n_checks++;
    if (s_wvalid !== 1'b1 || s_wdata !== e_wdata) begin
      n_errors++; $display("FAIL mask_wdata: got valid=%b data=%h expected %h", s_wvalid, s_wdata, e_wdata);
    end
    n_checks++;
    if ({awid, awlen, awsize, awburst, wlast} !== {4'd0, 8'd0, 3'b110, 2'b01, 1'b1} || wstrb !== {64{1'b1}}) begin
      n_errors++; $display("FAIL beat_attrs: got id=%h len=%h size=%b burst=%b last=%b strb=%h",
                           awid, awlen, awsize, awburst, wlast, wstrb);
    end
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    tick();
    n_checks++;
    if (s_cnt !== 8'd0 || s_idle !== 1'b1) begin
      n_errors++; $display("FAIL mask_drain: got cnt=%0d idle=%b expected cnt=0 idle=1", s_cnt, s_idle);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, aw_beats = 0, w_beats = 0, first_aw = -1, last_aw = -1, peak = 0, bad = 0;
    int b_due[$];
    idle_inputs();
    for (int c = 0; c < 24; c++) begin
      req_valid = (acc < 8);
      req_addr  = rand_addr();
      req_data  = rand_line();
      bvalid    = (b_due.size() > 0 && b_due[0] == c);
      tick();
      if (bvalid) void'(b_due.pop_front());
      if (s_grant && req_valid) acc++;
      if (s_awvalid && awready) begin
        b_due.push_back(c + 2);
        aw_beats++;
        if (first_aw < 0) first_aw = c;
        last_aw = c;
      end
      if (s_wvalid && wready) w_beats++;
      if (int'(s_cnt) > peak) peak = int'(s_cnt);
      if (s_ctl !== e_ctl || (e_awvalid && s_awaddr !== e_awaddr) || (e_wvalid && s_wdata !== e_wdata)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL b2b_cycles: got %0d mismatching cycles expected 0", bad);
    end
    n_checks++;
    if (acc != 8 || aw_beats != 8 || w_beats != 8 || (last_aw - first_aw) != 7) begin
      n_errors++; $display("FAIL b2b_beats: got acc=%0d aw=%0d w=%0d span=%0d expected 8 8 8 span 7",
                           acc, aw_beats, w_beats, last_aw - first_aw);
    end
    n_checks++;
    if (peak < 2 || peak > 3 || s_idle !== 1'b1) begin
      n_errors++; $display("FAIL b2b_peak: got peak=%0d idle=%b expected peak 2..3 idle=1", peak, s_idle);
    end
  endtask

  task automatic test_skewed();
    idle_inputs();
    req_valid = 1'b1;
    req_addr  = 64'h1000;
    awready   = 1'b0;
    tick();
    n_checks++;
    if (s_grant !== 1'b1) begin
      n_errors++; $display("FAIL skew_accept: got grant=%b expected 1", s_grant);
    end
    req_addr = rand_addr();
    req_data = rand_line();
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (s_grant !== 1'b0 || s_awvalid !== 1'b1 || s_awaddr !== 64'h1000 || s_wvalid !== (k == 1)) begin
        n_errors++; $display("FAIL skew_wait%0d: got grant=%b awv=%b awaddr=%h wv=%b expected 0 1 1000 %b",
                             k, s_grant, s_awvalid, s_awaddr, s_wvalid, (k == 1));
      end
    end
    awready = 1'b1;
    tick();
    n_checks++;
    if (s_awvalid !== 1'b1 || s_awaddr !== 64'h1000 || s_grant !== 1'b1) begin
      n_errors++; $display("FAIL skew_aw: got awv=%b awaddr=%h grant=%b expected 1 1000 1", s_awvalid, s_awaddr, s_grant);
    end
    req_valid = 1'b0;
    tick();
    bvalid = 1'b1;
    repeat (2) tick();
    bvalid = 1'b0;
    tick();
    n_checks++;
    if (s_ctl !== e_ctl || s_idle !== 1'b1) begin
      n_errors++; $display("FAIL skew_drain: got %b expected %b", s_ctl, e_ctl);
    end
  endtask

  task automatic test_credit();
    int acc = 0;
    idle_inputs();
    req_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_addr = rand_addr();
      tick();
      if (s_grant) acc++;
    end
    n_checks++;
    if (acc != MAXO || s_grant !== 1'b0 || s_cnt !== 8'(MAXO)) begin
      n_errors++; $display("FAIL credit_limit: got acc=%0d grant=%b cnt=%0d expected %0d 0 %0d",
                           acc, s_grant, s_cnt, MAXO, MAXO);
    end
    bvalid = 1'b1;
    tick();
    n_checks++;
    if (s_grant !== 1'b1) begin
      n_errors++; $display("FAIL credit_regrant: got grant=%b expected 1", s_grant);
    end
    bvalid = 1'b0;
    req_valid = 1'b0;
    tick();
    n_checks++;
    if (s_cnt !== 8'(MAXO) || s_cnt !== e_cnt) begin
      n_errors++; $display("FAIL credit_hold: got cnt=%0d expected %0d", s_cnt, MAXO);
    end
    bvalid = 1'b1;
    repeat (MAXO) tick();
    bvalid = 1'b0;
    tick();
    n_checks++;
    if (s_idle !== 1'b1 || s_err !== 1'b0) begin
      n_errors++; $display("FAIL credit_drain: got idle=%b err=%b expected 1 0", s_idle, s_err);
    end
  endtask

  task automatic test_errors();
    idle_inputs();
    req_valid = 1'b1;
    repeat (2) tick();
    req_valid = 1'b0;
    tick();
    bvalid = 1'b1;
    bresp  = 2'b10;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    tick();
    n_checks++;
    if (s_err !== 1'b1 || s_err !== e_err) begin
      n_errors++; $display("FAIL err_slverr: got err=%b expected 1", s_err);
    end
    bvalid = 1'b1; bresp = 2'b10; err_clear = 1'b1;
    tick();
    bvalid = 1'b0; bresp = 2'b00; err_clear = 1'b0;
    tick();
    n_checks++;
    if (s_err !== 1'b1 || s_cnt !== 8'd0) begin
      n_errors++; $display("FAIL err_set_wins: got err=%b cnt=%0d expected 1 0", s_err, s_cnt);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tick();
    n_checks++;
    if (s_err !== 1'b0) begin
      n_errors++; $display("FAIL err_clear: got err=%b expected 0", s_err);
    end
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    tick();
    n_checks++;
    if (s_err !== 1'b1 || s_cnt !== 8'd0 || s_idle !== 1'b1) begin
      n_errors++; $display("FAIL err_spurious: got err=%b cnt=%0d idle=%b expected 1 0 1", s_err, s_cnt, s_idle);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    req_valid = 1'b1;
    repeat (3) tick();
    req_valid = 1'b0;
    awready   = 1'b0;
    tick();
    n_checks++;
    if (s_awvalid !== 1'b1 || s_cnt !== 8'd3) begin
      n_errors++; $display("FAIL midrst_setup: got awv=%b cnt=%0d expected 1 3", s_awvalid, s_cnt);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || s_cnt !== 8'd0 || s_idle !== 1'b1) begin
      n_errors++; $display("FAIL midrst_drop: got awv=%b wv=%b cnt=%0d idle=%b expected 0 0 0 1",
                           s_awvalid, s_wvalid, s_cnt, s_idle);
    end
    awready = 1'b1;
    bvalid  = 1'b1;
    tick();
    bvalid = 1'b0;
    tick();
    n_checks++;
    if (s_err !== 1'b1 || s_cnt !== 8'd0) begin
      n_errors++; $display("FAIL midrst_late_b: got err=%b cnt=%0d expected 1 0", s_err, s_cnt);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      req_valid = $urandom_range(0, 1);
      req_addr  = rand_addr();
      req_data  = rand_line();
      awready   = ($urandom_range(0, 9) < 7);
      wready    = ($urandom_range(0, 9) < 7);
      bvalid    = (m_cnt > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 59) == 0);
      bresp     = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
      err_clear = ($urandom_range(0, 7) == 0);
      tick();
      if (s_ctl !== e_ctl || (e_awvalid && s_awaddr !== e_awaddr) || (e_wvalid && s_wdata !== e_wdata)) begin
        bad++;
        if (bad <= 5) $display("FAIL random_cycle%0d: got ctl=%b awaddr=%h expected ctl=%b awaddr=%h",
                               c, s_ctl, s_awaddr, e_ctl, e_awaddr);
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL random_total: got %0d mismatching cycles expected 0", bad);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_address_mask();
    test_back_to_back();
    test_skewed();
    test_credit();
    test_errors();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
